// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the seven-segment readback decoder.
// Optional sequence checking is enabled with SEVEN_SEG_DECODER_SEQ_CHECK_EN.
package seven_seg_pkg;

   typedef logic [6:0] seg_pat_t;

   typedef enum logic [1:0] {
      SETTLE,
      COMMIT,
      HOLD
   } state_e;

   // Glyph for nibble i, bit 6 = segment A.
   localparam seg_pat_t GLYPH [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79,
      7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F,
      7'h4E, 7'h3D, 7'h4F, 7'h47
   };

endpackage

// File: rtl/seven_seg_decoder_if.sv
// Pattern-to-nibble bundle between a digit and its glyph decoder.
// The master drives the pattern; the slave returns the nibble and legality.
interface seven_seg_decoder_if;
   import seven_seg_pkg::*;

   seg_pat_t   pattern;
   logic [3:0] nibble;
   logic       legal;

   modport master (
      output pattern,
      input  nibble,
      input  legal
   );

   modport slave (
      input  pattern,
      output nibble,
      output legal
   );

endinterface

// File: rtl/seven_seg_decoder_glyph_decode.sv
// Combinational lookup of one 7-bit segment pattern into a hex nibble.
// Any pattern outside the glyph table, blank included, is illegal.
module seven_seg_glyph_decode
   import seven_seg_pkg::*;
(
   seven_seg_decoder_if.slave g
);

   logic [3:0] nib;
   logic       ok;

   always_comb begin
      nib = '0;
      ok  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (g.pattern == GLYPH[i]) begin
            nib = 4'(i);
            ok  = 1'b1;
         end
      end
   end

   assign g.nibble = nib;
   assign g.legal  = ok;

endmodule

// File: rtl/seven_seg_decoder.sv
// Reads back a two-digit active-low seven-segment display and commits the byte.
// SEVEN_SEG_DECODER_SEQ_CHECK_EN adds a sticky o_Seq_Err count-sequence check.
module seven_seg_decoder
   import seven_seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Segment1_A,
   input  logic       i_Segment1_B,
   input  logic       i_Segment1_C,
   input  logic       i_Segment1_D,
   input  logic       i_Segment1_E,
   input  logic       i_Segment1_F,
   input  logic       i_Segment1_G,
   input  logic       i_Segment2_A,
   input  logic       i_Segment2_B,
   input  logic       i_Segment2_C,
   input  logic       i_Segment2_D,
   input  logic       i_Segment2_E,
   input  logic       i_Segment2_F,
   input  logic       i_Segment2_G,
   output logic [7:0] o_Value,
   output logic       o_Valid,
   output logic       o_Error
`ifdef SEVEN_SEG_DECODER_SEQ_CHECK_EN
   ,
   output logic       o_Seq_Err
`endif
);

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   logic [13:0] pins;
   logic [13:0] sync1;
   logic [13:0] sync2;
   logic [13:0] prev_q;
   logic [13:0] held_q;
   state_e      state;
   state_e      state_nxt;
   logic [7:0]  cnt;
   logic [7:0]  value_q;
   logic        legal_q;
   logic        chg;
   logic        held_chg;
   logic        commit_go;
   logic        legal_w;
   logic [7:0]  value_w;

   assign pins = {
      i_Segment1_A, i_Segment1_B, i_Segment1_C,
      i_Segment1_D, i_Segment1_E, i_Segment1_F,
      i_Segment1_G,
      i_Segment2_A, i_Segment2_B, i_Segment2_C,
      i_Segment2_D, i_Segment2_E, i_Segment2_F,
      i_Segment2_G
   };

   assign chg       = sync2 != prev_q;
   assign held_chg  = sync2 != held_q;
   assign commit_go = (state == SETTLE)
                   && (cnt == CNT_LAST);

   seven_seg_decoder_if d1_if ();
   seven_seg_decoder_if d2_if ();

   // Decode the last stable sample, not the live one.
   assign d1_if.pattern = ~prev_q[13:7];
   assign d2_if.pattern = ~prev_q[6:0];

   seven_seg_glyph_decode u_dec1 (.g(d1_if.slave));
   seven_seg_glyph_decode u_dec2 (.g(d2_if.slave));

   assign legal_w = d1_if.legal && d2_if.legal;
   assign value_w = {d1_if.nibble, d2_if.nibble};

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sync1  <= '1;
         sync2  <= '1;
         prev_q <= '1;
      end else begin
         sync1  <= pins;
         sync2  <= sync1;
         prev_q <= sync2;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state <= SETTLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         SETTLE: begin
            if (cnt == CNT_LAST) state_nxt = COMMIT;
         end
         COMMIT: begin
            state_nxt = held_chg ? SETTLE : HOLD;
         end
         HOLD: begin
            if (held_chg) state_nxt = SETTLE;
         end
         default: state_nxt = SETTLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cnt     <= '0;
         value_q <= '0;
         legal_q <= 1'b0;
         held_q  <= '1;
      end else begin
         if (state != SETTLE || chg) begin
            cnt <= '0;
         end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
         end
         // Snapshot the window pattern as it enters COMMIT.
         if (commit_go) begin
            held_q  <= prev_q;
            legal_q <= legal_w;
            if (legal_w) value_q <= value_w;
         end
      end
   end

   always_comb begin
      o_Valid = 1'b0;
      o_Error = 1'b0;
      if (state == COMMIT) begin
         o_Valid = legal_q;
         o_Error = !legal_q;
      end
   end

   assign o_Value = value_q;

`ifdef SEVEN_SEG_DECODER_SEQ_CHECK_EN
   logic seen_q;
   logic seq_err_q;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         seen_q    <= 1'b0;
         seq_err_q <= 1'b0;
      end else if (commit_go && legal_w) begin
         seen_q <= 1'b1;
         if (seen_q && value_w != value_q + 8'd1) begin
            seq_err_q <= 1'b1;
         end
      end
   end

   assign o_Seq_Err = seq_err_q;
`endif

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Self-checking bench: glyph table vectors plus a timed pulse scoreboard.
// Define SEVEN_SEG_DECODER_SEQ_CHECK_EN to also exercise o_Seq_Err.
module tb_seven_seg_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg1 = 7'h7F;
   logic [6:0] seg2 = 7'h7F;
   logic [7:0] o_value;
   logic       o_valid;
   logic       o_error;
`ifdef SEVEN_SEG_DECODER_SEQ_CHECK_EN
   logic       o_seq_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_pulse = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   seven_seg_decoder #(.STABLE_CYCLES(16)) dut (
      .i_Clk(clk),
      .i_Rst_L(rst_n),
      .i_Segment1_A(seg1[6]),
      .i_Segment1_B(seg1[5]),
      .i_Segment1_C(seg1[4]),
      .i_Segment1_D(seg1[3]),
      .i_Segment1_E(seg1[2]),
      .i_Segment1_F(seg1[1]),
      .i_Segment1_G(seg1[0]),
      .i_Segment2_A(seg2[6]),
      .i_Segment2_B(seg2[5]),
      .i_Segment2_C(seg2[4]),
      .i_Segment2_D(seg2[3]),
      .i_Segment2_E(seg2[2]),
      .i_Segment2_F(seg2[1]),
      .i_Segment2_G(seg2[0]),
      .o_Value(o_value),
      .o_Valid(o_valid),
      .o_Error(o_error)
`ifdef SEVEN_SEG_DECODER_SEQ_CHECK_EN
      ,
      .o_Seq_Err(o_seq_err)
`endif
   );

   seven_seg_decoder_if g_if ();
   seven_seg_glyph_decode u_glyph (.g(g_if.slave));

   logic [6:0] tb_glyph [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79,
      7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F,
      7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   typedef struct {
      int         cyc;
      bit         err;
      logic [7:0] val;
      bit         chk_seq;
      bit         seq;
   } exp_t;

   typedef struct {
      logic [6:0] s1;
      logic [6:0] s2;
      bit         err;
      logic [7:0] val;
   } vec_t;

   exp_t exp_q[$];

   task automatic check(input string name,
                        input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] p1,
                        input logic [6:0] p2);
      seg1 = ~p1;
      seg2 = ~p2;
   endtask

   task automatic expect_at(input int c, input bit err,
                            input logic [7:0] val,
                            input bit chk, input bit seq);
      exp_t e;
      e.cyc = c;
      e.err = err;
      e.val = val;
      e.chk_seq = chk;
      e.seq = seq;
      exp_q.push_back(e);
   endtask

   // Pulse scoreboard: every pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid && o_error) begin
            n_cmp++;
            n_bad++;
            $display("FAIL both_pulses at cyc %0d", cyc);
         end
         while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_pulse: none by cyc %0d want cyc %0d",
                     cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (o_valid || o_error) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pulse: cyc %0d err %0b val %0h",
                        cyc, o_error, o_value);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               n_cmp++;
               if (e.cyc != cyc || e.err != o_error
                   || e.val != o_value) begin
                  n_bad++;
                  $display("FAIL pulse: got cyc %0d err %0b val %0h want cyc %0d err %0b val %0h",
                           cyc, o_error, o_value, e.cyc, e.err, e.val);
               end
`ifdef SEVEN_SEG_DECODER_SEQ_CHECK_EN
               if (e.chk_seq) begin
                  n_cmp++;
                  if (o_seq_err != e.seq) begin
                     n_bad++;
                     $display("FAIL seq_err: got %0b want %0b at cyc %0d",
                              o_seq_err, e.seq, cyc);
                  end
               end
`endif
            end
         end
      end
   end

   vec_t vecs [10];
   logic [7:0] model;
   int c0;
   int n0;

   initial begin
      vecs[0] = '{7'h7E, 7'h30, 1'b0, 8'h01};
      vecs[1] = '{7'h6D, 7'h79, 1'b0, 8'h23};
      vecs[2] = '{7'h33, 7'h5B, 1'b0, 8'h45};
      vecs[3] = '{7'h00, 7'h7E, 1'b1, 8'h00};
      vecs[4] = '{7'h5F, 7'h70, 1'b0, 8'h67};
      vecs[5] = '{7'h7F, 7'h7B, 1'b0, 8'h89};
      vecs[6] = '{7'h77, 7'h1F, 1'b0, 8'hAB};
      vecs[7] = '{7'h7E, 7'h7C, 1'b1, 8'h00};
      vecs[8] = '{7'h4E, 7'h3D, 1'b0, 8'hCD};
      vecs[9] = '{7'h4F, 7'h47, 1'b0, 8'hEF};

      // Standalone glyph decoder: all legal glyphs and some illegal ones.
      for (int i = 0; i < 16; i++) begin
         g_if.pattern = tb_glyph[i];
         #1;
         check($sformatf("glyph_nib_%0d", i), int'(g_if.nibble), i);
         check($sformatf("glyph_legal_%0d", i), int'(g_if.legal), 1);
      end
      g_if.pattern = 7'h00;
      #1;
      check("glyph_blank", int'(g_if.legal), 0);
      g_if.pattern = 7'h01;
      #1;
      check("glyph_01", int'(g_if.legal), 0);
      g_if.pattern = 7'h7C;
      #1;
      check("glyph_7C", int'(g_if.legal), 0);

      // Reset state.
      tick(3);
      check("rst_value", int'(o_value), 0);
      check("rst_valid", int'(o_valid), 0);
      check("rst_error", int'(o_error), 0);
`ifdef SEVEN_SEG_DECODER_SEQ_CHECK_EN
      check("rst_seq_err", int'(o_seq_err), 0);
`endif

      // First commit: 0x12, latency 2 + 16 + 1.
      drive(7'h30, 7'h6D);
      rst_n = 1'b1;
      c0 = cyc;
      expect_at(c0 + 19, 1'b0, 8'h12, 1'b0, 1'b0);
      model = 8'h12;
      tick(25);

      // Illegal digit: error pulse, value kept; then a long quiet hold.
      drive(7'h7E, 7'h01);
      c0 = cyc;
      expect_at(c0 + 19, 1'b1, model, 1'b0, 1'b0);
      tick(25);
      n0 = n_pulse;
      tick(1000);
      check("hold_no_pulse", n_pulse - n0, 0);
      check("hold_value", int'(o_value), int'(model));

      // Table of pattern pairs, one commit window each.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].s1, vecs[i].s2);
         c0 = cyc;
         if (!vecs[i].err) model = vecs[i].val;
         expect_at(c0 + 19, vecs[i].err, model, 1'b0, 1'b0);
         tick(25);
      end

      // Brief excursion and back to the committed pattern re-commits it.
      drive(7'h7F, 7'h7F);
      tick(3);
      drive(7'h4F, 7'h47);
      c0 = cyc;
      expect_at(c0 + 19, 1'b0, model, 1'b0, 1'b0);
      tick(25);

      // Glitch mid-window restarts the 16-sample window.
      rst_n = 1'b0;
      tick(2);
      model = 8'h00;
      drive(7'h30, 7'h6D);
      rst_n = 1'b1;
      c0 = cyc;
      tick(8);
      drive(7'h30, 7'h7F);
      tick(5);
      drive(7'h30, 7'h6D);
      c0 = cyc;
      expect_at(c0 + 19, 1'b0, 8'h12, 1'b0, 1'b0);
      model = 8'h12;
      tick(25);

      // Reset with the counter at 10 aborts; full window after release.
      drive(7'h79, 7'h33);
      c0 = cyc;
      tick(13);
      rst_n = 1'b0;
      #1;
      check("abort_value", int'(o_value), 0);
      check("abort_valid", int'(o_valid), 0);
      check("abort_error", int'(o_error), 0);
      tick(3);
      rst_n = 1'b1;
      c0 = cyc;
      expect_at(c0 + 19, 1'b0, 8'h34, 1'b0, 1'b0);
      model = 8'h34;
      tick(25);

`ifdef SEVEN_SEG_DECODER_SEQ_CHECK_EN
      // Sequence 0x12, 0x13, 0x15: only the last breaks the count.
      rst_n = 1'b0;
      tick(2);
      drive(7'h30, 7'h6D);
      rst_n = 1'b1;
      c0 = cyc;
      expect_at(c0 + 19, 1'b0, 8'h12, 1'b1, 1'b0);
      tick(25);
      drive(7'h30, 7'h79);
      c0 = cyc;
      expect_at(c0 + 19, 1'b0, 8'h13, 1'b1, 1'b0);
      tick(25);
      drive(7'h30, 7'h5B);
      c0 = cyc;
      expect_at(c0 + 19, 1'b0, 8'h15, 1'b1, 1'b1);
      tick(25);
      drive(7'h30, 7'h5F);
      c0 = cyc;
      expect_at(c0 + 19, 1'b0, 8'h16, 1'b1, 1'b1);
      tick(25);
      check("seq_sticky", int'(o_seq_err), 1);
      rst_n = 1'b0;
      #1;
      check("seq_cleared", int'(o_seq_err), 0);
      drive(7'h7F, 7'h7F);
      tick(2);
`endif

      // Drain any outstanding expectations within a bounded wait.
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
      while (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover: pulse for cyc %0d never seen",
                  exp_q[0].cyc);
         void'(exp_q.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
